score_bcd_converter: RTL and testbench
======================================

// Module: score_bcd_converter
// PURPOSE
//  Iterative binary-to-BCD converter (double-dabble, one bit per clock) between
//  score_counter/combo_counter and the 7-seg display drivers. Takes a start-
//  qualified binary value, produces packed BCD digits, holds the last result
//  stable so HEX digits never show intermediate states. Saturates at all-9s.
// PARAMETERS
//  BIN_WIDTH   14  width of binary input (14 bits covers 0..9999)
//  NUM_DIGITS  4   BCD digits produced; max representable = 10^NUM_DIGITS-1
// PORTS
//  clk       in   1              system clock (CLOCK_50)
//  rst       in   1              asynchronous, active-low reset
//  value     in   BIN_WIDTH      binary value to convert; sampled on accepted start
//  start     in   1              request conversion (level, sampled each edge)
//  busy      out  1              conversion in progress
//  done      out  1              one-cycle pulse: bcd/overflow just updated
//  bcd       out  4*NUM_DIGITS   packed BCD, digit 0 = bits [3:0] (ones)
//  overflow  out  1              last converted value exceeded max; bcd forced to 9s
//  blank     out  NUM_DIGITS     leading-zero mask (only with LEADING_ZERO_BLANK_EN)
// BEHAVIOUR
//  - One clock domain. Only reset is async; all else on posedge clk.
//  - Reset (rst=0): state=IDLE, busy=0, done=0, bcd=0, overflow=0, pending=0,
//    blank=all 1s except digit 0. Reset mid-conversion aborts; no done issued.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE (or DONE -> SHIFT if pending).
//  - IDLE: start=1 at edge E0 captures value into shift reg, clears scratch BCD,
//    bit counter=0, busy=1, state=SHIFT.
//  - SHIFT: each edge, every scratch digit >=5 gets +3, then {scratch,shift}<<1.
//    Counter increments; after BIN_WIDTH shifts -> DONE.
//  - DONE (one cycle): bcd<=scratch (or all 9s if captured value >
//    10^NUM_DIGITS-1), overflow<=compare result, done=1, busy=0.
//  - Latency: start at E0 -> done high for the cycle after edge E0+BIN_WIDTH+1.
//    busy high from E0 until done edge. Throughput: one result per BIN_WIDTH+2.
//  - bcd/overflow change only on the done edge; stable otherwise.
//  - start while busy: sets pending (single-deep, coalesces repeats). In DONE,
//    if pending, clear it and recapture current value next edge (back-to-back).
//  - start held high continuously: conversions repeat back-to-back.
//  - Overflow compare on captured value, in full BIN_WIDTH arithmetic; value
//    exactly 10^NUM_DIGITS-1 is not overflow.
//  - Scratch BCD width 4*NUM_DIGITS; carry out of top digit ignored (covered by
//    saturation).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: blank[i]=1 when digit i and all digits above
//    it are 0, for i>=1; blank[0]=0 always. Updated with bcd on done edge.
//    Overflow: blank=0.
//  Not defined: blank tied to 0 (port kept for uniform hookup).
// TESTING
//  1 value=0, start pulse -> done after 16 cycles (BIN_WIDTH=14), bcd=16'h0000,
//    overflow=0.
//  2 value=1234 -> bcd=16'h1234; value=9999 -> bcd=16'h9999, overflow=0.
//  3 value=12000 -> bcd=16'h9999, overflow=1; next value=7 -> overflow=0, bcd=16'h0007.
//  4 start(value=55), at cycle 5 start(value=808) twice -> exactly two done pulses,
//    back-to-back, bcd 16'h0055 then 16'h0808; bcd stable between them.
//  5 rst low at cycle 8 of a conversion -> busy=0, bcd=0, no done; start after
//    release converts normally.
//  6 LEADING_ZERO_BLANK_EN, value=42 -> blank=4'b1100; value=0 -> blank=4'b1110;
//    macro undefined -> blank=0 always.

Source files
------------

// File: rtl/score_bcd_if.sv
// Request/result bundle between the score logic and the BCD converter.
// The converter is the slave; the score/combo counter side is the master.
interface score_bcd_if #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
);
  logic [BIN_WIDTH-1:0]    value;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    overflow;
  logic [NUM_DIGITS-1:0]   blank;

  modport master (output value, start, input busy, done, bcd, overflow, blank);
  modport slave  (input value, start, output busy, done, bcd, overflow, blank);
endinterface

// File: rtl/score_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, saturating at all 9s.
// Optional leading-zero blanking mask is enabled by defining LEADING_ZERO_BLANK_EN.
module score_bcd_converter #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  score_bcd_if.slave bus
);
  localparam int     BCD_W    = 4 * NUM_DIGITS;
  localparam int     CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam longint MAX_L    = longint'(10) ** NUM_DIGITS - longint'(1);
  // Wide inputs only; a narrow input can never exceed the display range.
  localparam bit     MAX_FITS = MAX_L < (longint'(1) << BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] MAX_VAL   = BIN_WIDTH'(MAX_L);
  localparam logic [BCD_W-1:0]     ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [BIN_WIDTH-1:0]   shift_r;
  logic [BCD_W-1:0]       scratch_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   pending_r;
  logic                   ovf_cap_r;
  logic                   busy_r;
  logic                   done_r;
  logic [BCD_W-1:0]       bcd_r;
  logic                   overflow_r;
  logic [BCD_W-1:0]       scr_next_s;
  logic [BIN_WIDTH-1:0]   sh_next_s;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One double-dabble step: add-3 correction, then shift the combined register left.
  always_comb begin
    {scr_next_s, sh_next_s} = {dabble_adjust(scratch_r), shift_r} << 1'b1;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_r;

  function automatic logic [NUM_DIGITS-1:0] zero_mask(input logic [BCD_W-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (d[4*i +: 4] == 4'd0);
      m[i]       = upper_zero;
    end
    return m;
  endfunction

  // Blank mask follows bcd on the done edge; saturated results are never blanked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_r <= ~NUM_DIGITS'(1'b1);
    end else if (state_r == S_DONE) begin
      blank_r <= ovf_cap_r ? '0 : zero_mask(scratch_r);
    end else begin
      blank_r <= blank_r;
    end
  end

  assign bus.blank = blank_r;
`else
  assign bus.blank = '0;
`endif

  // Control FSM with datapath; result registers move only on the done edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      shift_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      pending_r  <= 1'b0;
      ovf_cap_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // A request queued during the previous conversion starts here.
          if (bus.start || pending_r) begin
            shift_r   <= bus.value;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_cap_r <= MAX_FITS && (bus.value > MAX_VAL);
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_r <= scr_next_s;
          shift_r   <= sh_next_s;
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(BIN_WIDTH - 1)) begin
            state_r <= S_DONE;
          end
          if (bus.start) begin
            pending_r <= 1'b1;
          end
        end
        S_DONE: begin
          bcd_r      <= ovf_cap_r ? ALL_NINES : scratch_r;
          overflow_r <= ovf_cap_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= S_IDLE;
          if (bus.start) begin
            pending_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: expected results are queued at stimulus
// time and checked when done pulses; bcd stability is checked on every other cycle.
module tb_score_bcd_converter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] last_bcd;

  score_bcd_if #(.BIN_WIDTH(14), .NUM_DIGITS(4)) bus ();

  score_bcd_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   t;
    e.ovf   = (v > 9999);
    t       = e.ovf ? 9999 : v;
    e.bcd   = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    e.blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    if (!e.ovf) begin
      e.blank[3] = (t < 1000);
      e.blank[2] = (t < 100);
      e.blank[1] = (t < 10);
    end
`endif
    return e;
  endfunction

  // Monitor: score each done pulse, otherwise require the held result to stay put.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        check_eq("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("bcd", 32'(bus.bcd), 32'(e.bcd));
          check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
          check_eq("blank", 32'(bus.blank), 32'(e.blank));
          last_bcd = e.bcd;
        end
      end else begin
        check_eq("bcd_stable", 32'(bus.bcd), 32'(last_bcd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Start one conversion, measure cycles until done and confirm busy/done around it.
  task automatic convert(input int v);
    int lat;
    bus.value = 14'(v);
    bus.start = 1'b1;
    exp_q.push_back(model(v));
    step();
    bus.start = 1'b0;
    lat = 1;
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd16);
    check_eq("busy_at_done", 32'(bus.busy), 32'd0);
    step();
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dones;
    int d1;
    int d2;
    n_checks  = 0;
    n_fail    = 0;
    last_bcd  = 16'h0000;
    rst       = 1'b0;
    bus.value = 14'd0;
    bus.start = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_bcd", 32'(bus.bcd), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check_eq("rst_blank", 32'(bus.blank), 32'h0000_000E);
`else
    check_eq("rst_blank", 32'(bus.blank), 32'd0);
`endif
    rst = 1'b1;
    step();

    // Basic conversions, range edge, saturation and recovery, blanking patterns.
    convert(0);
    convert(1234);
    convert(9999);
    convert(12000);
    convert(7);
    convert(42);
    convert(10000);
    convert(16383);
    convert(0);
    convert(500);

    // Second request arrives twice mid-conversion and coalesces into one queued run.
    bus.value = 14'd55;
    bus.start = 1'b1;
    exp_q.push_back(model(55));
    step();
    bus.start = 1'b0;
    n     = 1;
    dones = 0;
    d1    = 0;
    d2    = 0;
    while (n < 60) begin
      if (n == 5) begin
        bus.value = 14'd808;
        bus.start = 1'b1;
        exp_q.push_back(model(808));
      end else if (n == 7) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (dones == 1) d1 = n;
        else d2 = n;
      end
      step();
      n++;
    end
    bus.start = 1'b0;
    check_eq("b2b_done_count", 32'(dones), 32'd2);
    check_eq("b2b_first_done", 32'(d1), 32'd16);
    check_eq("b2b_spacing", 32'(d2 - d1), 32'd16);

    // Reset in the middle of a conversion aborts it without a done pulse.
    bus.value = 14'd777;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    rst      = 1'b0;
    last_bcd = 16'h0000;
    #1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_bcd", 32'(bus.bcd), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_overflow", 32'(bus.overflow), 32'd0);
    step();
    rst = 1'b1;
    repeat (20) step();
    convert(321);

    repeat (4) step();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
